bmult_seq: RTL and testbench

- Parametrised, multi-cycle shift-add multiplier.
- Successor to the fixed 10x10 single-stage Bmult.
- Consumes RADIX_BITS bits of B per cycle.
- Supports signed or unsigned operation per transaction.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths and hw-eval harnesses without external operand registers.

---
 rtl/bmult_seq.sv | 129 ++++++++++++
 tb/tb_bmult_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmult_seq.sv
// Multi-cycle shift-add multiplier retiring RADIX_BITS multiplier bits per cycle,
// with valid/ready handshakes on both sides and per-transaction signed/unsigned mode.
module bmult_seq #(
    parameter int WIDTH_A    = 10,
    parameter int WIDTH_B    = 10,
    parameter int RADIX_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       is_signed,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] P,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);
    localparam int ITER = (WIDTH_B + RADIX_BITS - 1) / RADIX_BITS;
    localparam int BPAD = ITER * RADIX_BITS;
    localparam int PW   = WIDTH_A + WIDTH_B;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high in IDLE, and in DONE it follows out_ready so a new operand pair can
    // be taken in the same cycle the finished product is consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH_A-1:0] mag_a_q, mag_a_d;
    logic [BPAD-1:0]   b_sh_q, b_sh_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic [WIDTH_A-1:0] a_mag;
    logic [WIDTH_B-1:0] b_mag;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     acc_sum;
    int unsigned       shamt;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Magnitudes of the most negative values still fit as unsigned operand-width values.
    assign a_mag = (is_signed && A[WIDTH_A-1]) ? -A : A;
    assign b_mag = (is_signed && B[WIDTH_B-1]) ? -B : B;

    assign partial = PW'(mag_a_q) * PW'(b_sh_q[RADIX_BITS-1:0]);
    assign shamt   = RADIX_BITS * int'(cnt_q);
    assign acc_sum = acc_q + (partial << shamt);

    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        b_sh_d      = b_sh_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            BUSY: begin
                acc_d  = acc_sum;
                b_sh_d = b_sh_q >> RADIX_BITS;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    p_d         = neg_q ? -acc_sum : acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // A new pair may arrive from IDLE or straight out of DONE; either way start fresh.
        if (accept) begin
            mag_a_d = a_mag;
            b_sh_d  = BPAD'(b_mag);
            neg_d   = is_signed & (A[WIDTH_A-1] ^ B[WIDTH_B-1]);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_a_q     <= '0;
            b_sh_q      <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_a_q     <= mag_a_d;
            b_sh_q      <= b_sh_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == BUSY);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_bmult_seq.sv
// Bench for bmult_seq: four parameter sets, each with its own driver, expected queue and
// output monitor; the default set runs the directed scenarios, the others a corner/random mix.
module tb_bmult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int WA   = (g == 0) ? 10 : (g == 1) ? 16 : (g == 2) ? 8  : 10;
        localparam int WB   = (g == 0) ? 10 : (g == 1) ? 16 : (g == 2) ? 13 : 10;
        localparam int RB   = (g == 0) ? 2  : (g == 1) ? 4  : (g == 2) ? 3  : 1;
        localparam int ITER = (WB + RB - 1) / RB;
        localparam int PW   = WA + WB;

        logic          rst       = 1'b0;
        logic          in_valid  = 1'b0;
        logic          is_signed = 1'b0;
        logic          out_ready = 1'b0;
        logic [WA-1:0] a         = '0;
        logic [WB-1:0] b         = '0;
        logic          in_ready, out_valid, busy;
        logic [PW-1:0] p;
        logic [1:0]    st;

        logic [PW-1:0] exp_q[$];
        int            lat_q[$];
        int            last_acc = 0;

        bmult_seq #(.WIDTH_A(WA), .WIDTH_B(WB), .RADIX_BITS(RB)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .is_signed (is_signed),
            .A         (a),
            .B         (b),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .P         (p),
            .busy      (busy),
            .dbg_state (st)
        );

        function automatic logic [PW-1:0] ref_mul(input logic [WA-1:0] x, input logic [WB-1:0] y,
                                                  input logic s);
            longint xs, ys;
            xs = s ? longint'($signed(x)) : longint'(x);
            ys = s ? longint'($signed(y)) : longint'(y);
            return PW'(xs * ys);
        endfunction

        // Call #1 after a rising edge; returns #1 after the accepting edge.
        task automatic send(input logic [WA-1:0] x, input logic [WB-1:0] y, input logic s,
                            input logic [PW-1:0] e);
            bit ok;
            ok        = 1'b0;
            a         = x;
            b         = y;
            is_signed = s;
            in_valid  = 1'b1;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
            end
            #1;
            if (!ok) fail_now($sformatf("accept_timeout[%0d]", g));
            else begin
                exp_q.push_back(e);
                lat_q.push_back(cyc);
                last_acc = cyc;
            end
            in_valid = 1'b0;
        endtask

        task automatic drain();
            for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
            check($sformatf("drain[%0d]", g), 64'(exp_q.size()), 0);
            @(posedge clk);
            #1;
        endtask

        initial begin : mon
            logic ov_prev;
            ov_prev = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) ov_prev = 1'b0;
                else begin
                    if (out_valid && !ov_prev) begin
                        if (lat_q.size() == 0) fail_now($sformatf("unexpected_valid[%0d]", g));
                        else check($sformatf("latency[%0d]", g), 64'(cyc - lat_q.pop_front()), ITER);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) fail_now($sformatf("unexpected_product[%0d]", g));
                        else check($sformatf("product[%0d]", g), 64'(p), 64'(exp_q.pop_front()));
                    end
                    ov_prev = out_valid;
                end
            end
        end

        if (g == 0) begin : dir
            initial begin : drv
                logic [WA-1:0] va [6] = '{10'h200, 10'h3FF, 10'h000, 10'h3FF, 10'h200, 10'h3FF};
                logic [WB-1:0] vb [6] = '{10'h200, 10'h005, 10'h3F9, 10'h005, 10'h1FF, 10'h3FF};
                logic          vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
                logic [PW-1:0] ve [6] = '{20'h40000, 20'hFFFFB, 20'h00000, 20'h013FB,
                                          20'hC0200, 20'h00001};
                int            prev;
                logic          seen;
                logic [WA-1:0] x;
                logic [WB-1:0] y;
                logic          s;

                #2 rst = 1'b1;
                #1;
                check("rst_p", 64'(p), 0);
                check("rst_out_valid", 64'(out_valid), 0);
                check("rst_busy", 64'(busy), 0);
                check("rst_in_ready", 64'(in_ready), 1);
                check("rst_state", 64'(st), 0);
                repeat (2) @(posedge clk);
                @(negedge clk) rst = 1'b0;
                @(posedge clk);
                #1;

                send(10'd1023, 10'd1023, 1'b0, 20'hFF801);
                for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_p", 64'(p), 20'hFF801);
                    check("bp_out_valid", 64'(out_valid), 1);
                    check("bp_in_ready", 64'(in_ready), 0);
                end
                check("bp_state", 64'(st), 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                send(10'd3, 10'd4, 1'b0, 20'd12);
                check("b2b_busy", 64'(busy), 1);
                check("b2b_in_ready", 64'(in_ready), 0);
                check("b2b_out_valid", 64'(out_valid), 0);

                for (int i = 0; i < 6; i++) begin
                    prev = last_acc;
                    send(va[i], vb[i], vs[i], ve[i]);
                    check("throughput_corner", 64'(last_acc - prev), ITER + 1);
                end

                for (int i = 0; i < 20; i++) begin
                    x    = WA'($urandom_range(0, (1 << WA) - 1));
                    y    = WB'($urandom_range(0, (1 << WB) - 1));
                    s    = 1'($urandom_range(0, 1));
                    prev = last_acc;
                    send(x, y, s, ref_mul(x, y, s));
                    check("throughput_stream", 64'(last_acc - prev), ITER + 1);
                end
                drain();

                send(10'd100, 10'd200, 1'b0, 20'd20000);
                @(posedge clk);
                @(posedge clk);
                #2;
                rst = 1'b1;
                exp_q.delete();
                lat_q.delete();
                #1;
                check("midrst_p", 64'(p), 0);
                check("midrst_out_valid", 64'(out_valid), 0);
                check("midrst_busy", 64'(busy), 0);
                @(negedge clk) rst = 1'b0;
                seen = 1'b0;
                repeat (ITER + 3) begin
                    @(negedge clk);
                    seen = seen | out_valid;
                end
                check("midrst_no_stale_valid", 64'(seen), 0);
                @(posedge clk);
                #1;
                send(10'd7, 10'd9, 1'b0, 20'd63);
                drain();
                n_done++;
            end
        end else begin : rnd
            initial begin : bp
                forever begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end

            initial begin : drv
                logic [WA-1:0] amax, amin, x;
                logic [WB-1:0] bmax, bmin, y;
                logic          s;
                amax = '1;
                bmax = '1;
                amin = '0;
                amin[WA-1] = 1'b1;
                bmin = '0;
                bmin[WB-1] = 1'b1;

                #2 rst = 1'b1;
                #1;
                check($sformatf("rst_p[%0d]", g), 64'(p), 0);
                check($sformatf("rst_state[%0d]", g), 64'(st), 0);
                repeat (2) @(posedge clk);
                @(negedge clk) rst = 1'b0;
                @(posedge clk);
                #1;

                send(amax, bmax, 1'b0, ref_mul(amax, bmax, 1'b0));
                send(amin, bmin, 1'b1, ref_mul(amin, bmin, 1'b1));
                send(amin, bmax, 1'b1, ref_mul(amin, bmax, 1'b1));
                send(amax, bmax, 1'b1, ref_mul(amax, bmax, 1'b1));
                send('0, bmin, 1'b1, ref_mul('0, bmin, 1'b1));
                send(amax, bmin, 1'b0, ref_mul(amax, bmin, 1'b0));
                for (int i = 0; i < 40; i++) begin
                    x = WA'($urandom_range(0, (1 << WA) - 1));
                    y = WB'($urandom_range(0, (1 << WB) - 1));
                    s = 1'($urandom_range(0, 1));
                    send(x, y, s, ref_mul(x, y, s));
                end
                drain();
                n_done++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && n_done < 4; i++) @(posedge clk);
        if (n_done < 4) fail_now("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
